vga_plot_sink: RTL and testbench
================================

# vga_plot_sink

Consumer end of the pixel-plot interface used by the shape drawers (circle, line, fill). It accepts one (x, y, colour) write per clock when `plot` is high and stores it in an internal 160×120×3-bit framebuffer. It continuously scans the framebuffer out as 640×480@60 Hz VGA, with each stored pixel replicated 4×4. It sits between the drawing FSMs and the DE2 VGA DAC pins.

## Interface
Parameters:
- `SCREEN_WIDTH`, default 160: framebuffer columns.
- `SCREEN_HEIGHT`, default 120: framebuffer rows.

Ports:
- `CLOCK_50` in 1: system clock, 50 MHz. This is the only clock.
- `resetn` in 1: asynchronous, active-low reset.
- `x` in 8: plot column.
- `y` in 7: plot row.
- `colour` in 3: colour as {R,G,B}.
- `plot` in 1: write strobe, sampled every CLOCK_50 edge.
- `busy` out 1: high while plots are being ignored (clear sweep in progress).
- `VGA_R`, `VGA_G`, `VGA_B` out 10 each: DAC colour.
- `VGA_HS`, `VGA_VS` out 1: syncs, active low.
- `VGA_BLANK` out 1: high during the visible region.
- `VGA_SYNC` out 1: constant 0.
- `VGA_CLK` out 1: 25 MHz pixel clock.

## Operation
- **Write path**
  - When `plot`=1, `busy`=0, `x`<160 and `y`<120: write `colour` to address y*160+x on that same edge.
  - Address is 15 bits, computed as (y<<7)+(y<<5)+x.
  - Out-of-range plots are silently dropped. No wrap-around.
  - There is no back-pressure. Every accepted strobe is written; a write every cycle is legal.
- **Pixel enable**
  - `pe` toggles every CLOCK_50 cycle and is 0 on the first edge after reset.
  - `VGA_CLK` is the registered `pe`.
- **Scan counters** (advance only when `pe`=1)
  - `hcount` runs 0..799; `vcount` runs 0..524.
  - `vcount` increments when `hcount` wraps 799→0.
- **Horizontal timing:** visible 0–639, front porch 640–655, sync 656–751, back porch 752–799.
- **Vertical timing:** visible 0–479, front porch 480–489, sync 490–491, back porch 492–524.
- **Read path**
  - Read address = (vcount>>2)*160 + (hcount>>2) while visible.
  - Outside the visible region, RGB is forced to 0.
- **Colour expansion:** each colour bit is replicated to all 10 bits of its channel, so 1→0x3FF and 0→0x000.
- **Read-during-write** to the same address returns the old data. The new pixel appears on the next scan of that location.
- **Clear FSM** (see Configuration)
  - States: CLEAR → RUN.
  - CLEAR writes BLACK to address 0..19199, one address per CLOCK_50 cycle, then moves to RUN.
  - RUN is terminal until reset.

## Timing
- **Reset values (all outputs):**
  - `VGA_R`/`VGA_G`/`VGA_B` = 0.
  - `VGA_HS` = `VGA_VS` = 1.
  - `VGA_BLANK` = 0, `VGA_SYNC` = 0, `VGA_CLK` = 0.
  - `busy` = 1 if the clear feature is compiled in, else 0.
  - Counters = 0; clear address = 0.
- **Pipeline:** counter → registered RAM address → RAM data → output register. That is 2 pixel clocks (4 CLOCK_50 cycles).
  - HS, VS and BLANK are delayed by the same 2 pixel clocks, so all pins stay aligned.
- **Line/frame periods:** HS period is 1600 CLOCK_50 cycles, low for 192. VS period is 525 lines, low for 2 lines.
- **Write latency:** 1 CLOCK_50 edge into RAM.
- **Reset mid-frame:** all outputs return to their reset values immediately (asynchronous). The scan restarts at (0,0). Framebuffer contents are undefined unless the clear feature re-runs.

## Configuration
- Macro: `VGA_PLOT_SINK_CLEAR_EN`.
- **Defined:**
  - After every reset deassertion, the CLEAR sweep runs for 19200 cycles with `busy`=1.
  - Plots are ignored during the sweep; `busy` falls on the cycle after address 19199 is written.
  - Scan-out runs during the sweep and shows partially cleared content.
- **Not defined:**
  - No FSM; `busy` is tied to 0.
  - The RAM is power-up initialised to all zeros; reset does not clear it.

## Structure
- Package `vga_pkg`:
  - Screen dimensions.
  - The 640×480 porch/sync/total constants.
  - Colour constants BLACK, BLUE, GREEN, YELLOW, RED, WHITE.
  - Typedefs `x_t` (8 bits), `y_t` (7 bits), `colour_t` (3 bits), `fb_addr_t` (15 bits).
- Sub-module `vga_timing`: the `pe` generator, hcount/vcount, and raw HS/VS/visible signals.
- The framebuffer is an inferred simple dual-port RAM inside `vga_plot_sink`.

## Test plan
- **Reset check:** assert `resetn`=0 mid-frame → every output at its reset value within the same cycle. After release, the first HS falling edge occurs 4+656*2 CLOCK_50 cycles later.
- **Sync timing:** free-run two frames → HS period 1600 cycles and low 192; VS period 840000 cycles and low 3200. `VGA_BLANK` high for exactly 1280 cycles per visible line.
- **Plot and scan:** plot (40,60,RED) → on lines 240–243, pixels 160–163 show R=0x3FF, G=0, B=0. Neighbouring pixels stay 0.
- **Out-of-range:** plot (160,0,WHITE) and (0,120,WHITE) → no change anywhere. Specifically, (0,1) and (159,119) still read their prior values.
- **Read-during-write:** plot (0,0,WHITE) on the exact cycle address 0 is read → the current frame shows the old value; the next frame shows 0x3FF on all channels.
- **Clear (macro on):** plot (5,5,GREEN) with `busy`=1 → ignored. `busy` falls 19200 cycles after reset; the frame is fully black. Plot (5,5,GREEN) afterwards → G=0x3FF at lines 20–23, pixels 20–23.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared constants and types for the pixel-plot VGA sink.
//   Screen dimensions, 640x480@60 porch/sync/total constants, colour
//   constants, plot/framebuffer typedefs, clear FSM state type and small
//   address/colour helpers.
package vga_pkg;

   localparam int unsigned SCREEN_W  = 160;
   localparam int unsigned SCREEN_H  = 120;
   localparam int unsigned FB_DEPTH  = SCREEN_W * SCREEN_H;

   localparam int unsigned X_W       = 8;
   localparam int unsigned Y_W       = 7;
   localparam int unsigned COLOUR_W  = 3;
   localparam int unsigned FB_ADDR_W = 15;
   localparam int unsigned DAC_W     = 10;
   localparam int unsigned CNT_W     = 10;

   // Horizontal timing in pixel clocks
   localparam int unsigned H_VISIBLE    = 640;
   localparam int unsigned H_FRONT      = 16;
   localparam int unsigned H_SYNC       = 96;
   localparam int unsigned H_BACK       = 48;
   localparam int unsigned H_SYNC_START = H_VISIBLE + H_FRONT;
   localparam int unsigned H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int unsigned H_TOTAL      = H_SYNC_END + H_BACK;

   // Vertical timing in lines
   localparam int unsigned V_VISIBLE    = 480;
   localparam int unsigned V_FRONT      = 10;
   localparam int unsigned V_SYNC       = 2;
   localparam int unsigned V_BACK       = 33;
   localparam int unsigned V_SYNC_START = V_VISIBLE + V_FRONT;
   localparam int unsigned V_SYNC_END   = V_SYNC_START + V_SYNC;
   localparam int unsigned V_TOTAL      = V_SYNC_END + V_BACK;

   typedef logic [X_W-1:0]       x_t;
   typedef logic [Y_W-1:0]       y_t;
   typedef logic [COLOUR_W-1:0]  colour_t;
   typedef logic [FB_ADDR_W-1:0] fb_addr_t;

   // Colours are {R,G,B}
   localparam colour_t BLACK  = 3'b000;
   localparam colour_t BLUE   = 3'b001;
   localparam colour_t GREEN  = 3'b010;
   localparam colour_t YELLOW = 3'b110;
   localparam colour_t RED    = 3'b100;
   localparam colour_t WHITE  = 3'b111;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } clr_state_t;

   // row*160 + col without a multiplier
   function automatic fb_addr_t fb_addr(input x_t col, input y_t row);
      return (fb_addr_t'(row) << 7) + (fb_addr_t'(row) << 5) + fb_addr_t'(col);
   endfunction

   // One colour bit drives the whole DAC channel
   function automatic logic [DAC_W-1:0] dac_level(input logic bit_on);
      return {DAC_W{bit_on}};
   endfunction

endpackage

// File: rtl/vga_plot_sink_timing.sv
// vga_timing: pixel-enable generator and 640x480@60 scan counters.
//   clk       in  : system clock (50 MHz)
//   rst_n     in  : asynchronous active-low reset
//   pe        out : pixel enable, toggles every clk, 0 on the first edge after reset
//   hcount    out : column counter 0..799, advances when pe=1
//   vcount    out : line counter 0..524, advances when hcount wraps
//   hs_c      out : raw horizontal sync (active low), combinational
//   vs_c      out : raw vertical sync (active low), combinational
//   visible_c out : raw visible-region flag, combinational
module vga_timing
   import vga_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   output logic             pe,
   output logic [CNT_W-1:0] hcount,
   output logic [CNT_W-1:0] vcount,
   output logic             hs_c,
   output logic             vs_c,
   output logic             visible_c
);

   localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOTAL - 1);
   localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOTAL - 1);
   localparam logic [CNT_W-1:0] H_VIS   = CNT_W'(H_VISIBLE);
   localparam logic [CNT_W-1:0] V_VIS   = CNT_W'(V_VISIBLE);
   localparam logic [CNT_W-1:0] H_SYN_S = CNT_W'(H_SYNC_START);
   localparam logic [CNT_W-1:0] H_SYN_E = CNT_W'(H_SYNC_END);
   localparam logic [CNT_W-1:0] V_SYN_S = CNT_W'(V_SYNC_START);
   localparam logic [CNT_W-1:0] V_SYN_E = CNT_W'(V_SYNC_END);

   // Pixel enable and raster counters
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pe     <= 1'b0;
         hcount <= '0;
         vcount <= '0;
      end else begin
         pe <= ~pe;
         if (pe) begin
            if (hcount == H_LAST) begin
               hcount <= '0;
               vcount <= (vcount == V_LAST) ? '0 : vcount + CNT_W'(1);
            end else begin
               hcount <= hcount + CNT_W'(1);
            end
         end
      end
   end

   // Raw sync/visible decode of the current counter position
   assign hs_c      = !((hcount >= H_SYN_S) && (hcount < H_SYN_E));
   assign vs_c      = !((vcount >= V_SYN_S) && (vcount < V_SYN_E));
   assign visible_c = (hcount < H_VIS) && (vcount < V_VIS);

endmodule

// File: rtl/vga_plot_sink.sv
// vga_plot_sink: stores (x, y, colour) plots in a 160x120x3 framebuffer and
// scans it out as 640x480@60 VGA with 4x4 pixel replication.
//   CLOCK_50   in  : 50 MHz system clock (only clock)
//   resetn     in  : asynchronous active-low reset
//   x, y       in  : plot column (8b) / row (7b)
//   colour     in  : plot colour {R,G,B}
//   plot       in  : write strobe, sampled every edge
//   busy       out : plots ignored while high (clear sweep)
//   VGA_R/G/B  out : 10-bit DAC channels
//   VGA_HS/VS  out : active-low syncs
//   VGA_BLANK  out : high in the visible region
//   VGA_SYNC   out : constant 0
//   VGA_CLK    out : 25 MHz pixel clock (registered pixel enable)
// Build option: define VGA_PLOT_SINK_CLEAR_EN to black out the framebuffer
// after every reset (busy high for 19200 cycles). Without it the RAM relies on
// power-up zero contents and is untouched by reset.
module vga_plot_sink
   import vga_pkg::*;
#(
   parameter int unsigned SCREEN_WIDTH  = SCREEN_W,
   parameter int unsigned SCREEN_HEIGHT = SCREEN_H
) (
   input  logic               CLOCK_50,
   input  logic               resetn,
   input  logic [X_W-1:0]     x,
   input  logic [Y_W-1:0]     y,
   input  logic [COLOUR_W-1:0] colour,
   input  logic               plot,
   output logic               busy,
   output logic [DAC_W-1:0]   VGA_R,
   output logic [DAC_W-1:0]   VGA_G,
   output logic [DAC_W-1:0]   VGA_B,
   output logic               VGA_HS,
   output logic               VGA_VS,
   output logic               VGA_BLANK,
   output logic               VGA_SYNC,
   output logic               VGA_CLK
);

   localparam int unsigned DEPTH = SCREEN_WIDTH * SCREEN_HEIGHT;

   logic             pe;
   logic [CNT_W-1:0] hcount;
   logic [CNT_W-1:0] vcount;
   logic             hs_c;
   logic             vs_c;
   logic             visible_c;

   vga_timing u_timing (
      .clk       (CLOCK_50),
      .rst_n     (resetn),
      .pe        (pe),
      .hcount    (hcount),
      .vcount    (vcount),
      .hs_c      (hs_c),
      .vs_c      (vs_c),
      .visible_c (visible_c)
   );

   // ---------------------------------------------------------------- write port
   logic     plot_ok_c;
   logic     wr_en_c;
   fb_addr_t wr_addr_c;
   colour_t  wr_data_c;

   // Out-of-range plots are dropped rather than wrapped
   assign plot_ok_c = plot && !busy &&
                      (32'(x) < SCREEN_WIDTH) && (32'(y) < SCREEN_HEIGHT);

`ifdef VGA_PLOT_SINK_CLEAR_EN
   localparam fb_addr_t CLR_LAST = fb_addr_t'(DEPTH - 1);

   clr_state_t state, state_nxt;
   fb_addr_t   clr_addr, clr_addr_nxt;
   logic       busy_nxt;
   logic       clr_we_c;

   // Clear FSM state register
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         state    <= ST_CLEAR;
         clr_addr <= '0;
         busy     <= 1'b1;
      end else begin
         state    <= state_nxt;
         clr_addr <= clr_addr_nxt;
         busy     <= busy_nxt;
      end
   end

   // Sweep one address per cycle; busy drops together with the last write
   always_comb begin
      state_nxt    = state;
      clr_addr_nxt = clr_addr;
      busy_nxt     = busy;
      clr_we_c     = 1'b0;
      case (state)
         ST_CLEAR: begin
            clr_we_c = 1'b1;
            if (clr_addr == CLR_LAST) begin
               state_nxt = ST_RUN;
               busy_nxt  = 1'b0;
            end else begin
               clr_addr_nxt = clr_addr + fb_addr_t'(1);
            end
         end
         ST_RUN: busy_nxt = 1'b0;
         default: state_nxt = ST_RUN;
      endcase
   end

   // Clear sweep owns the write port while active
   always_comb begin
      wr_en_c   = plot_ok_c;
      wr_addr_c = fb_addr(x, y);
      wr_data_c = colour;
      if (clr_we_c) begin
         wr_en_c   = 1'b1;
         wr_addr_c = clr_addr;
         wr_data_c = BLACK;
      end
   end
`else
   assign busy = 1'b0;

   always_comb begin
      wr_en_c   = plot_ok_c;
      wr_addr_c = fb_addr(x, y);
      wr_data_c = colour;
   end
`endif

   // ---------------------------------------------------------------- framebuffer
   colour_t  fb_mem [DEPTH];
   fb_addr_t rd_addr;
   colour_t  rd_data;

   // Simple dual-port RAM; a same-address read returns the old contents
   always_ff @(posedge CLOCK_50) begin
      if (wr_en_c) fb_mem[wr_addr_c] <= wr_data_c;
      rd_data <= fb_mem[rd_addr];
   end

   // ---------------------------------------------------------------- scan-out
   logic vis_d;
   logic hs_d;
   logic vs_d;

   // Address and syncs registered on one pixel clock, RAM reads on the
   // following CLOCK_50 edge, pins registered on the next pixel clock:
   // everything lands two pixel clocks after the counters.
   always_ff @(posedge CLOCK_50 or negedge resetn) begin
      if (!resetn) begin
         rd_addr   <= '0;
         vis_d     <= 1'b0;
         hs_d      <= 1'b1;
         vs_d      <= 1'b1;
         VGA_R     <= '0;
         VGA_G     <= '0;
         VGA_B     <= '0;
         VGA_HS    <= 1'b1;
         VGA_VS    <= 1'b1;
         VGA_BLANK <= 1'b0;
         VGA_CLK   <= 1'b0;
      end else begin
         VGA_CLK <= pe;
         if (pe) begin
            rd_addr   <= visible_c ? fb_addr(x_t'(hcount >> 2), y_t'(vcount >> 2)) : '0;
            vis_d     <= visible_c;
            hs_d      <= hs_c;
            vs_d      <= vs_c;
            VGA_R     <= vis_d ? dac_level(rd_data[2]) : '0;
            VGA_G     <= vis_d ? dac_level(rd_data[1]) : '0;
            VGA_B     <= vis_d ? dac_level(rd_data[0]) : '0;
            VGA_BLANK <= vis_d;
            VGA_HS    <= hs_d;
            VGA_VS    <= vs_d;
         end
      end
   end

   assign VGA_SYNC = 1'b0;

endmodule

// File: tb/tb_vga_plot_sink.sv
// Bench for vga_plot_sink: random plots checked every cycle against a
// pixel-index model of the raster, plus literal timing/plot expectations.
module tb_vga_plot_sink;
   import vga_pkg::*;

`ifdef VGA_PLOT_SINK_CLEAR_EN
   localparam bit CLEAR_EN = 1'b1;
`else
   localparam bit CLEAR_EN = 1'b0;
`endif
   localparam int CLEAR_CYCLES = 19200;
   localparam int LINE         = 800;
   localparam int FRAME_LINES  = 525;
   localparam int END_K        = 66100;

   logic        CLOCK_50 = 1'b0;
   logic        resetn;
   x_t          x;
   y_t          y;
   colour_t     colour;
   logic        plot;
   logic        busy;
   logic [9:0]  VGA_R, VGA_G, VGA_B;
   logic        VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK;

   int n_checks = 0;
   int n_fail   = 0;
   int k        = 0;           // CLOCK_50 edges since reset release
   colour_t fbm [19200];
   colour_t snap    = BLACK;   // pixel fetched for display two edges later
   colour_t exp_col = BLACK;   // pixel currently on the pins

   vga_plot_sink dut (
      .CLOCK_50  (CLOCK_50),
      .resetn    (resetn),
      .x         (x),
      .y         (y),
      .colour    (colour),
      .plot      (plot),
      .busy      (busy),
      .VGA_R     (VGA_R),
      .VGA_G     (VGA_G),
      .VGA_B     (VGA_B),
      .VGA_HS    (VGA_HS),
      .VGA_VS    (VGA_VS),
      .VGA_BLANK (VGA_BLANK),
      .VGA_SYNC  (VGA_SYNC),
      .VGA_CLK   (VGA_CLK)
   );

   always #10 CLOCK_50 = ~CLOCK_50;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at k=%0d: got 0x%0h, expected 0x%0h", name, k, act, exp);
      end
   endtask

   // Edge after which pixel (h, v) of the first frame is on the pins
   function automatic int edge_of(input int v, input int h);
      return 2 * (v * LINE + h) + 4;
   endfunction

   function automatic colour_t pixel_colour(input int p);
      int h = p % LINE;
      int v = (p / LINE) % FRAME_LINES;
      if (h < 640 && v < 480) return fbm[(v / 4) * 160 + h / 4];
      return BLACK;
   endfunction

   function automatic logic [9:0] lvl(input logic b);
      return b ? 10'h3FF : 10'h000;
   endfunction

   // Model update and full-pin comparison after every edge
   always @(posedge CLOCK_50) begin : cmp
      int p, h, v;
      logic e_hs, e_vs, e_bl;
      logic [63:0] exp_v, act_v;
      #1;
      if (!resetn) begin
         k       = 0;
         snap    = BLACK;
         exp_col = BLACK;
         if (CLEAR_EN) for (int i = 0; i < 19200; i++) fbm[i] = BLACK;
      end else begin
         k++;
         if (plot && !(CLEAR_EN && k <= CLEAR_CYCLES) && int'(x) < 160 && int'(y) < 120)
            fbm[int'(y) * 160 + int'(x)] = colour;
         if (k >= 4 && k % 2 == 0) exp_col = snap;
         if (k >= 2 && k % 2 == 0) snap = pixel_colour((k - 2) / 2);
         if (k >= 4) begin
            p    = (k - 4) / 2;
            h    = p % LINE;
            v    = (p / LINE) % FRAME_LINES;
            e_hs = !(h >= 656 && h < 752);
            e_vs = !(v >= 490 && v < 492);
            e_bl = (h < 640 && v < 480);
         end else begin
            e_hs = 1'b1;
            e_vs = 1'b1;
            e_bl = 1'b0;
         end
         exp_v = {28'd0, (CLEAR_EN && k < CLEAR_CYCLES), lvl(exp_col[2]), lvl(exp_col[1]),
                  lvl(exp_col[0]), e_hs, e_vs, e_bl, 1'b0, (k % 2 == 0)};
         act_v = {28'd0, busy, VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_BLANK, VGA_SYNC, VGA_CLK};
         check("pins", act_v, exp_v);
      end
   end

   // Inputs for the upcoming edge ke
   task automatic drive(input int ke, input bit directed);
      plot   = 1'b0;
      x      = '0;
      y      = '0;
      colour = BLACK;
      if (directed && (ke == 100 || ke == 19300)) begin
         plot = 1'b1; x = 8'd5;   y = 7'd5;   colour = GREEN;
      end else if (directed && ke == 19302) begin
         plot = 1'b1; x = 8'd160; y = 7'd9;   colour = WHITE;
      end else if (directed && ke == 19304) begin
         plot = 1'b1; x = 8'd0;   y = 7'd120; colour = WHITE;
      end else if (directed && ke == 20803) begin
         plot = 1'b1; x = 8'd0;   y = 7'd3;   colour = WHITE;
      end else if ($urandom_range(0, 2) == 0) begin
         plot   = 1'b1;
         x      = x_t'($urandom_range(40, 170));
         y      = ($urandom_range(0, 15) == 0) ? y_t'($urandom_range(120, 127))
                                               : y_t'($urandom_range(0, 9));
         colour = colour_t'($urandom_range(0, 7));
      end
   endtask

   task automatic check_reset_pins();
      check("rst_R", VGA_R, 0);
      check("rst_G", VGA_G, 0);
      check("rst_B", VGA_B, 0);
      check("rst_HS", VGA_HS, 1);
      check("rst_VS", VGA_VS, 1);
      check("rst_BLANK", VGA_BLANK, 0);
      check("rst_SYNC", VGA_SYNC, 0);
      check("rst_CLK", VGA_CLK, 0);
      check("rst_busy", busy, CLEAR_EN);
   endtask

   initial begin : stim
      int fall_k;
      int blank_cnt;
      logic hs_prev;
      resetn = 1'b0;
      plot   = 1'b0;
      x      = '0;
      y      = '0;
      colour = BLACK;
      repeat (3) @(negedge CLOCK_50);
      check_reset_pins();
      resetn = 1'b1;

      // First run: sync onset, then a reset in the middle of the HS pulse
      while (k < 1340) begin
         @(negedge CLOCK_50);
         if (k == 1315) check("hs_before_sync", VGA_HS, 1);
         if (k == 1316) check("hs_sync_onset", VGA_HS, 0);
         drive(k + 1, 1'b0);
      end
      @(negedge CLOCK_50);
      check("hs_low_before_reset", VGA_HS, 0);
      #2 resetn = 1'b0;
      plot = 1'b0;
      #1 check_reset_pins();
      repeat (3) @(negedge CLOCK_50);
      resetn = 1'b1;

      // Second run: directed plots plus random traffic
      fall_k    = -1;
      blank_cnt = 0;
      hs_prev   = 1'b1;
      while (k < END_K) begin
         @(negedge CLOCK_50);
         if (VGA_HS == 1'b0 && hs_prev == 1'b1) begin
            if (fall_k < 0) check("first_hs_fall", k, 1316);
            else            check("hs_period", k - fall_k, 1600);
            fall_k = k;
         end
         if (VGA_HS == 1'b1 && hs_prev == 1'b0) check("hs_low", k - fall_k, 192);
         hs_prev = VGA_HS;
         if (k >= edge_of(2, 0) && k < edge_of(3, 0)) blank_cnt += int'(VGA_BLANK);
         if (k == edge_of(3, 0)) check("blank_per_line", blank_cnt, 1280);
         if (k == edge_of(20, 20)) begin
            check("green_l20_p20", VGA_G, 10'h3FF);
            check("green_l20_p20_red", VGA_R, 0);
            check("green_l20_p20_blue", VGA_B, 0);
         end
         if (k == edge_of(23, 23)) check("green_l23_p23", VGA_G, 10'h3FF);
         if (k == edge_of(20, 19)) check("left_neighbour", VGA_G, 0);
         if (k == edge_of(20, 24)) check("right_neighbour", VGA_G, 0);
         if (k == edge_of(19, 20)) check("upper_neighbour", VGA_G, 0);
         if (k == edge_of(24, 20)) check("lower_neighbour", VGA_G, 0);
         if (k == edge_of(13, 0))  check("rdw_old_value", VGA_R, 0);
         if (k == edge_of(13, 1))  check("rdw_new_value", {VGA_R, VGA_G, VGA_B}, 30'h3FFF_FFFF);
         if (k == edge_of(40, 0))  check("no_wrap_x160", {VGA_R, VGA_G, VGA_B}, 0);
         drive(k + 1, 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
